mma_tile_scheduler: RTL and testbench
=====================================

// Module: mma_tile_scheduler
// PURPOSE
//  Shares one tensor_core_fp16_mma tile between NUM_REQ requesters. Round-robin
//  arbitration, operand-mux select, mma_valid issue and result_valid wait per job.
//  A per-job watchdog aborts hung jobs. Sits between compute clients and the core;
//  the datapath muxes A/B/C by gnt_idx and demuxes D.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  TIMEOUT_CYC  1024  max cycles in WAIT before abort (>=4)
//  IDX_W        $clog2(NUM_REQ)  width of grant index (derived, localparam)
// PORTS
//  clk               in   1        clock, all logic on posedge
//  rst               in   1        asynchronous, active-high reset
//  req               in   NUM_REQ  level request per client; held until done/err
//  gnt               out  NUM_REQ  one-hot owner of core, 0 when idle
//  gnt_idx           out  IDX_W    binary owner index, drives operand/result muxes
//  done              out  NUM_REQ  1-cycle pulse: owner's D valid this cycle
//  err               out  NUM_REQ  1-cycle pulse: owner's job timed out
//  busy              out  1        core owned (ISSUE or WAIT)
//  mma_enable        out  1        core enable; 1 whenever rst low
//  mma_valid         out  1        1-cycle start pulse to core
//  mma_ready         in   1        core can accept start
//  result_valid      in   1        core D valid (level or pulse; rising edge used)
// BEHAVIOUR
//  Reset: state=IDLE; gnt=0, gnt_idx=0, done=0, err=0, busy=0, mma_valid=0,
//   mma_enable=0, rr_ptr=0, wdog=0, rv_q=0. All outputs registered.
//  FSM IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
//  IDLE: if |req, pick first set bit at/after rr_ptr (circular); register gnt,
//   gnt_idx, busy=1; go ISSUE. Grant visible cycle after req sampled.
//  ISSUE: mma_valid=1 exactly on cycles where mma_ready=1, then WAIT next cycle;
//   stays in ISSUE (mma_valid=0) while mma_ready=0. Never two mma_valid per job.
//  WAIT: rising edge of result_valid (result_valid & ~rv_q) -> done[gnt_idx]=1
//   that same registered cycle, go RELEASE. A result_valid already high on entry
//   to WAIT is ignored (stale from prior job). wdog counts from 0 in WAIT; at
//   wdog==TIMEOUT_CYC-1 with no edge -> err[gnt_idx]=1, go RELEASE.
//  RELEASE: gnt=0, busy=0, rr_ptr=gnt_idx+1 (wrap to 0 at NUM_REQ); -> IDLE.
//   Min job turnaround: 4 cycles + core latency; no back-to-back without IDLE.
//  Edge on result_valid coincident with timeout terminal count: done wins.
//  Requester dropping req mid-job: job completes; done still pulsed.
//  Any req bit toggling while busy does not change gnt.
//  done and err never both set; at most one bit of done|err set per cycle.
//  rst asserted mid-job: immediate return to reset values; core mma_valid drops
//   asynchronously; in-flight result discarded, no done.
//  result_valid edge outside WAIT: ignored, no output effect.
// STRUCTURE
//  Package mma_sched_pkg: typedef enum logic[1:0] {S_IDLE,S_ISSUE,S_WAIT,S_RELEASE}
//   sched_state_e; default NUM_REQ/TIMEOUT_CYC constants; shared by bench.
//  Sub-module mma_rr_pick: combinational round-robin picker (req, rr_ptr ->
//   onehot, idx, any). Rotate-priority-rotate or double-width mask; parameterised
//   by NUM_REQ. FSM, watchdog, edge detect live in top.
// TESTING
//  1 Single req[2]=1, ready=1, result_valid after 6 cyc -> gnt=0100, gnt_idx=2,
//    one mma_valid pulse, done=0100 one cycle, rr_ptr=3.
//  2 req=1111 held, 8 jobs -> grant order 0,1,2,3,0,1,2,3; exactly 8 done pulses.
//  3 mma_ready=0 for 5 cyc in ISSUE -> mma_valid stays 0, then 1 for exactly one
//    cycle on first ready=1.
//  4 TIMEOUT_CYC=16, result_valid never rises -> err[idx] pulses 16 cyc after
//    WAIT entry, no done; next req then served normally.
//  5 result_valid held high from prior job into new WAIT -> no done until it falls
//    and rises again.
//  6 rst pulsed during WAIT -> all outputs 0 within same cycle, rr_ptr=0, no
//    done/err; after release req[1] granted first.

Source files
------------

// File: rtl/mma_sched_pkg.sv
// Shared scheduler types and default sizing for the MMA tile scheduler and its clients.
package mma_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE
  } sched_state_e;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/mma_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, circularly.
module mma_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pos = IDX_W'((32'(i_ptr) + i) % NUM_REQ);
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_idx           = w_pos;
        o_onehot[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mma_tile_scheduler.sv
// Time-shares one fp16 MMA tile between NUM_REQ clients: round-robin grant,
// single start pulse per job, result-edge completion and per-job watchdog abort.
module mma_tile_scheduler
  import mma_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               busy,
  output logic               mma_enable,
  output logic               mma_valid,
  input  logic               mma_ready,
  input  logic               result_valid
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

  sched_state_e       r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_err;
  logic               r_busy;
  logic               r_mma_enable;
  logic               r_mma_valid;
  logic               r_rv_q;
  logic [WD_W-1:0]    r_wdog;

  logic [NUM_REQ-1:0] w_onehot;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_rv_rise;

  mma_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req    (req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // rv_q tracks result_valid in every state, so a level already high on WAIT entry never looks like an edge
  assign w_rv_rise = result_valid & ~r_rv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_gnt_idx    <= '0;
      r_rr_ptr     <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_busy       <= 1'b0;
      r_mma_enable <= 1'b0;
      r_mma_valid  <= 1'b0;
      r_rv_q       <= 1'b0;
      r_wdog       <= '0;
    end else begin
      r_mma_enable <= 1'b1;
      r_rv_q       <= result_valid;
      r_done       <= '0;
      r_err        <= '0;
      r_mma_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_onehot;
            r_gnt_idx <= w_idx;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mma_ready) begin
            r_mma_valid <= 1'b1;
            r_wdog      <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // completion edge takes priority over the watchdog terminal count
          if (w_rv_rise) begin
            r_done[r_gnt_idx] <= 1'b1;
            r_state           <= S_RELEASE;
          end else if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
            r_err[r_gnt_idx] <= 1'b1;
            r_state          <= S_RELEASE;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        S_RELEASE: begin
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign gnt_idx    = r_gnt_idx;
  assign done       = r_done;
  assign err        = r_err;
  assign busy       = r_busy;
  assign mma_enable = r_mma_enable;
  assign mma_valid  = r_mma_valid;

endmodule

// File: tb/tb_mma_tile_scheduler.sv
// Directed bench for mma_tile_scheduler (NUM_REQ=4, TIMEOUT_CYC=16).
module tb_mma_tile_scheduler;
  import mma_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic [3:0] done;
  logic [3:0] err;
  logic       busy;
  logic       mma_enable;
  logic       mma_valid;
  logic       mma_ready;
  logic       result_valid;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_done = 0;
  int n_err = 0;
  int n_multi = 0;

  mma_tile_scheduler #(.NUM_REQ(DEF_NUM_REQ), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .gnt          (gnt),
    .gnt_idx      (gnt_idx),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .mma_enable   (mma_enable),
    .mma_valid    (mma_valid),
    .mma_ready    (mma_ready),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mma_valid) n_valid++;
    if (|done) n_done++;
    if (|err) n_err++;
    if (((done & err) != 4'b0) || ($countones(done | err) > 1)) n_multi++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (|gnt) begin to = 1'b0; break; end
      tick();
    end
  endtask

  task automatic wait_mv(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if (mma_valid) begin to = 1'b0; break; end
      tick();
    end
  endtask

  task automatic wait_fin(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      if ((|done) || (|err)) begin to = 1'b0; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; mma_ready = 1'b0; result_valid = 1'b0;
    tick(); tick();
    total++;
    if ({gnt, gnt_idx, done, err, busy, mma_enable, mma_valid} !== 17'b0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b idx=%0d done=%b err=%b busy=%b en=%b mv=%b want all 0",
               gnt, gnt_idx, done, err, busy, mma_enable, mma_valid);
    end
    rst = 1'b0;
    tick();
    total++;
    if (mma_enable !== 1'b1) begin bad++; $display("FAIL reset_enable: got %b want 1", mma_enable); end
    total++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin bad++; $display("FAIL reset_idle: got busy=%b gnt=%b want 0/0000", busy, gnt); end
  endtask

  task automatic test_single();
    bit to;
    int v0, d0;
    v0 = n_valid; d0 = n_done;
    mma_ready = 1'b1; result_valid = 1'b0; req = 4'b0100;
    wait_gnt(10, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL single_gnt_wait: got timeout want grant"); end
    total++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL single_gnt: got gnt=%b idx=%0d busy=%b want 0100/2/1", gnt, gnt_idx, busy);
    end
    wait_mv(10, to);
    total++;
    if (to !== 1'b0) begin bad++; $display("FAIL single_mv_wait: got timeout want mma_valid"); end
    repeat (6) tick();
    total++;
    if (done !== 4'b0) begin bad++; $display("FAIL single_early_done: got %b want 0000", done); end
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    wait_fin(10, to);
    total++;
    if (done !== 4'b0100 || err !== 4'b0) begin
      bad++; $display("FAIL single_done: got done=%b err=%b want 0100/0000", done, err);
    end
    req = '0;
    tick();
    total++;
    if (gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin
      bad++; $display("FAIL single_release: got gnt=%b busy=%b done=%b want 0000/0/0000", gnt, busy, done);
    end
    tick();
    total++;
    if (n_valid - v0 !== 1 || n_done - d0 !== 1) begin
      bad++; $display("FAIL single_pulses: got mv=%0d done=%0d want 1/1", n_valid - v0, n_done - d0);
    end
    // rr_ptr now 3: full request set must pick client 3
    req = 4'b1111;
    wait_gnt(10, to);
    total++;
    if (gnt !== 4'b1000) begin bad++; $display("FAIL single_rrptr: got gnt=%b want 1000", gnt); end
    wait_mv(10, to);
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    wait_fin(10, to);
    total++;
    if (done !== 4'b1000) begin bad++; $display("FAIL single_rrptr_done: got %b want 1000", done); end
    req = '0; tick(); tick();
  endtask

  task automatic test_round_robin();
    bit to;
    int v0, d0;
    logic [3:0] exp_oh;
    v0 = n_valid; d0 = n_done;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      wait_gnt(10, to);
      total++;
      if (to !== 1'b0 || gnt !== exp_oh) begin
        bad++; $display("FAIL rr_gnt[%0d]: got gnt=%b to=%b want %b", k, gnt, to, exp_oh);
      end
      wait_mv(10, to);
      repeat (2) tick();
      result_valid = 1'b1; tick(); result_valid = 1'b0;
      wait_fin(10, to);
      total++;
      if (done !== exp_oh) begin bad++; $display("FAIL rr_done[%0d]: got %b want %b", k, done, exp_oh); end
      tick();
    end
    req = '0; tick(); tick();
    total++;
    if (n_done - d0 !== 8 || n_valid - v0 !== 8) begin
      bad++; $display("FAIL rr_counts: got done=%0d mv=%0d want 8/8", n_done - d0, n_valid - v0);
    end
  endtask

  task automatic test_ready_stall();
    bit to;
    int stall_mv;
    stall_mv = 0;
    mma_ready = 1'b0; req = 4'b0010;
    wait_gnt(10, to);
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL stall_gnt: got %b want 0010", gnt); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mma_valid) stall_mv++;
    end
    total++;
    if (stall_mv !== 0) begin bad++; $display("FAIL stall_mv_low: got %0d pulses want 0", stall_mv); end
    mma_ready = 1'b1;
    tick();
    total++;
    if (mma_valid !== 1'b1) begin bad++; $display("FAIL stall_mv_high: got %b want 1", mma_valid); end
    tick();
    total++;
    if (mma_valid !== 1'b0) begin bad++; $display("FAIL stall_mv_once: got %b want 0", mma_valid); end
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    wait_fin(10, to);
    total++;
    if (done !== 4'b0010) begin bad++; $display("FAIL stall_done: got %b want 0010", done); end
    req = '0; tick(); tick();
  endtask

  task automatic test_timeout();
    bit to;
    int n;
    n = 0;
    req = 4'b0001;
    wait_gnt(10, to);
    wait_mv(10, to);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((|err) || (|done)) begin n = i; break; end
    end
    total++;
    if (n !== 16) begin bad++; $display("FAIL tmo_latency: got %0d cycles want 16", n); end
    total++;
    if (err !== 4'b0001 || done !== 4'b0) begin
      bad++; $display("FAIL tmo_err: got err=%b done=%b want 0001/0000", err, done);
    end
    req = '0; tick(); tick();
    req = 4'b0001;
    wait_gnt(10, to);
    wait_mv(10, to);
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    wait_fin(10, to);
    total++;
    if (done !== 4'b0001 || err !== 4'b0) begin
      bad++; $display("FAIL tmo_next_job: got done=%b err=%b want 0001/0000", done, err);
    end
    req = '0; tick(); tick();
  endtask

  task automatic test_stale_result();
    bit to;
    int d0;
    req = 4'b0100;
    wait_gnt(10, to);
    wait_mv(10, to);
    result_valid = 1'b1; tick();
    wait_fin(10, to);
    total++;
    if (done !== 4'b0100) begin bad++; $display("FAIL stale_first_done: got %b want 0100", done); end
    req = '0; tick();
    req = 4'b1000;
    wait_gnt(10, to);
    total++;
    if (gnt !== 4'b1000) begin bad++; $display("FAIL stale_gnt: got %b want 1000", gnt); end
    wait_mv(10, to);
    d0 = n_done;
    repeat (5) tick();
    result_valid = 1'b0; tick(); tick();
    total++;
    if (n_done !== d0) begin bad++; $display("FAIL stale_ignored: got %0d done pulses want 0", n_done - d0); end
    result_valid = 1'b1; tick();
    total++;
    if (done !== 4'b1000) begin bad++; $display("FAIL stale_new_edge: got %b want 1000", done); end
    result_valid = 1'b0; req = '0; tick(); tick();
  endtask

  task automatic test_reset_mid_job();
    bit to;
    int d0, e0;
    req = 4'b0100;
    wait_gnt(10, to);
    wait_mv(10, to);
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    wait_fin(10, to);
    req = '0; tick(); tick();
    req = 4'b0001;
    wait_gnt(10, to);
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL rstmid_gnt: got %b want 0001", gnt); end
    wait_mv(10, to);
    repeat (3) tick();
    d0 = n_done; e0 = n_err;
    rst = 1'b1;
    #1;
    total++;
    if ({gnt, gnt_idx, done, err, busy, mma_enable, mma_valid} !== 17'b0) begin
      bad++;
      $display("FAIL rstmid_async: got gnt=%b idx=%0d done=%b err=%b busy=%b en=%b mv=%b want all 0",
               gnt, gnt_idx, done, err, busy, mma_enable, mma_valid);
    end
    req = 4'b1110; result_valid = 1'b1;
    tick();
    rst = 1'b0; result_valid = 1'b0;
    wait_gnt(10, to);
    total++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
      bad++; $display("FAIL rstmid_first_gnt: got gnt=%b idx=%0d want 0010/1", gnt, gnt_idx);
    end
    total++;
    if (n_done !== d0 || n_err !== e0) begin
      bad++; $display("FAIL rstmid_no_pulse: got done=%0d err=%0d want 0/0", n_done - d0, n_err - e0);
    end
    wait_mv(10, to);
    result_valid = 1'b1; tick(); result_valid = 1'b0;
    wait_fin(10, to);
    total++;
    if (done !== 4'b0010) begin bad++; $display("FAIL rstmid_done: got %b want 0010", done); end
    req = '0; tick(); tick();
  endtask

  task automatic test_exclusive();
    total++;
    if (n_multi !== 0) begin bad++; $display("FAIL exclusive: got %0d overlapping cycles want 0", n_multi); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ready_stall();
    test_timeout();
    test_stale_result();
    test_reset_mid_job();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
